// File: rtl/gaussian_stream.sv
// gaussian_stream: fully pipelined 3x3 sixteenths-weighted window smoother with valid/ready backpressure
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   win_in              nine signed W-bit taps, tap k at [k*W +: W], row-major, k=4 centre
//   mode_in             kernel select (0 gaussian, 1 cross, 2/3 bypass), taken with the window
//   in_valid, in_ready  input handshake
//   out_data            filtered signed sample
//   out_valid, out_ready output handshake
//   busy                any pipeline stage holds a valid sample
//   in_count, out_count accepted / emitted sample counters, wrapping
module gaussian_stream #(
    parameter int W       = 27,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9*W-1:0]   win_in,
    input  logic [1:0]       mode_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);
    localparam int XW = W + 5;

    // The three-stage structure below is fixed; LATENCY only documents it.
    if (LATENCY != 3) begin : g_bad_latency
        $error("gaussian_stream: LATENCY must stay 3");
    end

    logic signed [XW-1:0] ext [9];
    logic signed [XW-1:0] tap_w [9];
    logic signed [XW-1:0] s1_d [5];
    logic signed [XW-1:0] s1_q [5];
    logic signed [XW-1:0] s2_a_d, s2_b_d, s2_a_q, s2_b_q, rnd;
    logic [W-1:0] out_d, out_q;
    logic s1_v_q, s2_v_q, out_v_q, adv;
    logic [CNT_W-1:0] in_cnt_q, out_cnt_q;

    genvar k;
    for (k = 0; k < 9; k++) begin : g_ext
        assign ext[k] = {{5{win_in[k*W+W-1]}}, win_in[k*W +: W]};
    end

    // Weights are powers of two, so each tap is a shift or zero.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            tap_w[i] = '0;
            if (i == 4)
                tap_w[i] = (mode_in == 2'd0) ? ext[i] <<< 2 : (mode_in == 2'd1) ? ext[i] <<< 3 : ext[i] <<< 4;
            else if (i % 2 == 1)
                tap_w[i] = mode_in[1] ? '0 : ext[i] <<< 1;
            else
                tap_w[i] = (mode_in == 2'd0) ? ext[i] : '0;
        end
        s1_d[0] = tap_w[0] + tap_w[1];
        s1_d[1] = tap_w[2] + tap_w[3];
        s1_d[2] = tap_w[4];
        s1_d[3] = tap_w[5] + tap_w[6];
        s1_d[4] = tap_w[7] + tap_w[8];
        s2_a_d  = s1_q[0] + s1_q[1];
        s2_b_d  = s1_q[2] + s1_q[3] + s1_q[4];
        // Round half up, then an arithmetic divide by 16 is just dropping the low four bits.
        rnd     = s2_a_q + s2_b_q + XW'(8);
        out_d   = rnd[W+3:4];
    end

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign adv = ~out_v_q | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '{default: '0};
            s2_a_q    <= '0;
            s2_b_q    <= '0;
            out_q     <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            out_v_q   <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (adv) begin
                s1_q    <= s1_d;
                s1_v_q  <= in_valid;
                s2_a_q  <= s2_a_d;
                s2_b_q  <= s2_b_d;
                s2_v_q  <= s1_v_q;
                out_q   <= out_d;
                out_v_q <= s2_v_q;
            end
            if (in_valid & adv)
                in_cnt_q <= in_cnt_q + CNT_W'(1);
            if (out_v_q & out_ready)
                out_cnt_q <= out_cnt_q + CNT_W'(1);
        end
    end

    assign in_ready  = adv;
    assign out_data  = out_q;
    assign out_valid = out_v_q;
    assign busy      = s1_v_q | s2_v_q | out_v_q;
    assign in_count  = in_cnt_q;
    assign out_count = out_cnt_q;
endmodule

// File: tb/tb_gaussian_stream.sv
// tb_gaussian_stream: randomized and directed checks of gaussian_stream against a sum-of-products model
module tb_gaussian_stream;
    localparam int W  = 27;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9*W-1:0] win_in = '0;
    logic [1:0] mode_in = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic [W-1:0] out_data;
    logic [CW-1:0] in_count, out_count;

    int total = 0;
    int bad = 0;
    int acc_n = 0;
    int con_n = 0;
    int rdy_mode = 0;
    int bp_i = 0;
    longint expq[$];
    longint obs[$];
    logic stall_q = 1'b0;
    logic [W-1:0] hold_q = '0;

    always #5 clk = ~clk;

    gaussian_stream #(.W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .win_in(win_in), .mode_in(mode_in),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .in_count(in_count), .out_count(out_count)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int wgt(input int m, input int k);
        if (m == 0) return (k == 4) ? 4 : (k % 2 == 1) ? 2 : 1;
        if (m == 1) return (k == 4) ? 8 : (k % 2 == 1) ? 2 : 0;
        return (k == 4) ? 16 : 0;
    endfunction

    // Weighted sum in sixteenths, then floor((sum + 8) / 16).
    function automatic longint model(input logic [9*W-1:0] w, input logic [1:0] m);
        longint s = 0;
        longint n, q;
        for (int k = 0; k < 9; k++)
            s += longint'($signed(w[k*W +: W])) * wgt(int'(m), k);
        n = s + 8;
        q = n / 16;
        if (n % 16 != 0 && n < 0) q--;
        return q;
    endfunction

    function automatic logic [9*W-1:0] put(input logic [9*W-1:0] w, input int k, input int v);
        w[k*W +: W] = W'(v);
        return w;
    endfunction

    function automatic logic [9*W-1:0] fill(input int v);
        logic [9*W-1:0] w = '0;
        for (int k = 0; k < 9; k++) w = put(w, k, v);
        return w;
    endfunction

    function automatic logic [9*W-1:0] rnd_win();
        logic [9*W-1:0] w = '0;
        for (int k = 0; k < 9; k++) w[k*W +: W] = W'($urandom);
        return w;
    endfunction

    always @(posedge clk) begin
        #1;
        bp_i++;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            acc_n = 0;
            con_n = 0;
            stall_q = 1'b0;
        end else begin
            chk("in_cnt", longint'(in_count), longint'(acc_n % 16));
            chk("out_cnt", longint'(out_count), longint'(con_n % 16));
            chk("rdy", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            if (stall_q) begin
                chk("hold_v", longint'(out_valid), 1);
                chk("hold_d", longint'($signed(out_data)), longint'($signed(hold_q)));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("spurious", expq.size(), 1);
                else chk("data", longint'($signed(out_data)), expq.pop_front());
                obs.push_back(longint'($signed(out_data)));
                con_n++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(win_in, mode_in));
                acc_n++;
            end
            stall_q = out_valid && !out_ready;
            hold_q = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [9*W-1:0] w, input logic [1:0] m);
        int s = acc_n;
        int n = 0;
        win_in = w;
        mode_in = m;
        in_valid = 1'b1;
        do begin
            step();
            n++;
        end while (acc_n == s && n < 100);
        if (n >= 100) chk("send_timeout", acc_n, s + 1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((expq.size() != 0 || busy) && n < 500) begin
            step();
            n++;
        end
        chk("drain_left", expq.size(), 0);
    endtask

    task automatic one(input string tag, input logic [9*W-1:0] w, input logic [1:0] m, input longint exp);
        int n;
        win_in = w;
        mode_in = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, 3);
        chk(tag, longint'($signed(out_data)), exp);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9*W-1:0] w;
        longint e[$];
        rst = 1'b1;
        step();
        step();
        chk("rst_ov", longint'(out_valid), 0);
        chk("rst_od", longint'(out_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_inc", longint'(in_count), 0);
        chk("rst_outc", longint'(out_count), 0);
        chk("rst_rdy", longint'(in_ready), 1);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", longint'(in_ready), 1);

        one("all16", fill(16), 2'd0, 16);
        one("allm16", fill(-16), 2'd0, -16);
        one("c160", put('0, 4, 160), 2'd0, 40);
        one("t1_8", put('0, 1, 8), 2'd0, 1);
        one("t0_1", put('0, 0, 1), 2'd0, 0);
        one("cm1", put('0, 4, -1), 2'd0, 0);
        one("t0_m9", put('0, 0, -9), 2'd0, -1);
        w = '0;
        for (int k = 0; k < 9; k++) w = put(w, k, k + 1);
        one("cross", w, 2'd1, 5);
        one("byp2", put(rnd_win(), 4, -12345), 2'd2, -12345);
        one("byp3", put(rnd_win(), 4, -12345), 2'd3, -12345);

        w = put(put(put('0, 0, 160), 1, 32), 4, 16);
        obs.delete();
        send(w, 2'd0);
        send(w, 2'd1);
        send(w, 2'd2);
        send(w, 2'd0);
        drain();
        chk("msw_n", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("msw0", obs[0], 18);
            chk("msw1", obs[1], 12);
            chk("msw2", obs[2], 16);
            chk("msw3", obs[3], 18);
        end

        do_rst();
        rdy_mode = 1;
        step();
        obs.delete();
        e.delete();
        for (int i = 0; i < 10; i++) begin
            w = rnd_win();
            mode_in = 2'($urandom_range(0, 3));
            e.push_back(model(w, mode_in));
            send(w, mode_in);
        end
        drain();
        chk("bp_n", obs.size(), 10);
        for (int i = 0; i < 10 && i < obs.size(); i++) chk("bp_order", obs[i], e[i]);
        chk("bp_inc", longint'(in_count), 10);
        chk("bp_outc", longint'(out_count), 10);

        rdy_mode = 3;
        step();
        step();
        for (int i = 0; i < 3; i++) send(rnd_win(), 2'($urandom_range(0, 3)));
        in_valid = 1'b0;
        chk("mid_busy", longint'(busy), 1);
        chk("mid_ov", longint'(out_valid), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_ov", longint'(out_valid), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_inc", longint'(in_count), 0);
        chk("mid_rst_outc", longint'(out_count), 0);
        rst = 1'b0;
        rdy_mode = 0;
        step();
        step();
        one("post_mid", fill(7), 2'd0, 7);

        do_rst();
        for (int i = 0; i < 17; i++) send(rnd_win(), 2'($urandom_range(0, 3)));
        drain();
        chk("wrap_inc", longint'(in_count), 1);
        chk("wrap_outc", longint'(out_count), 1);

        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end else begin
                send(rnd_win(), 2'($urandom_range(0, 3)));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
